serial_deserializer: RTL and testbench

Receive side of the on-chip bit-serial link. Accepts the LSB-first serial stream and its word-envelope signal produced by the link transmitter, both clocked on serial_clk. Reassembles each WIDTH-bit word and presents it on a valid/ready parallel output, backed by a single holding register. Flags overruns (word completes while the holding register is still occupied) and framing errors (envelope drops mid-word).

---
 rtl/serial_deserializer.sv | 138 +++++++++++++
 tb/tb_serial_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer: receive side of the on-chip bit-serial link.
//
// This block rebuilds WIDTH-bit words from an LSB-first serial stream that is
// qualified by the link_busy envelope. Each word is placed in a single
// holding register, which the consumer drains through an out_valid/out_ready
// handshake.
//
// overrun pulses for one cycle when a word completes while the holding
// register is still occupied and is not being drained on the same edge.
// frame_err pulses for one cycle when the envelope drops in the middle of
// a word.
//
// Optional feature: define SERDES_RX_ERR_CNT_EN to add a saturating error
// counter. It brings the err_count and err_clr ports with it. When the macro
// is left undefined, neither port exists and no counter logic is built.
module serial_deserializer #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 serial_clk,
  input  logic                 rst_n,
  input  logic                 serial_data,
  input  logic                 link_busy,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef SERDES_RX_ERR_CNT_EN
  output logic [CNT_WIDTH-1:0] err_count,
  input  logic                 err_clr,
`endif
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // Reject configurations the shift/count logic cannot represent.
  if (WIDTH < 2) begin : g_width_check
    $error("serial_deserializer: WIDTH must be at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("serial_deserializer: CNT_WIDTH must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  logic [WIDTH-1:0] shift_next;
  logic             word_done;
  logic             frame_evt;
  logic             drop_evt;

  // Next shift value, completion and error events for the current edge.
  always_comb begin
    shift_next = {serial_data, shift_reg[WIDTH-1:1]};
    word_done  = (state == SHIFT) && link_busy && (bit_cnt == LAST_IDX);
    frame_evt  = (state == SHIFT) && !link_busy;
    // The holding register is full and nobody drains it on this edge.
    drop_evt   = word_done && out_valid && !out_ready;
  end

  // Receive FSM, shift register, holding register and error pulses.
  // NOTE: every register here uses non-blocking assignment, so all
  // right-hand sides see pre-edge values no matter the statement order.
  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      // NOTE: shift_reg is cleared as well. A partial word must not survive
      // reset, and this keeps simulation free of X.
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= drop_evt;
      frame_err <= frame_evt;

      case (state)
        IDLE: begin
          if (link_busy) begin
            shift_reg <= shift_next;
            bit_cnt   <= CW'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!link_busy) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (word_done) begin
            shift_reg <= shift_next;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase

      // A completed word takes over the holding register whenever the old
      // word is gone or is being drained on this same edge.
      if (word_done && !drop_evt) begin
        out_data  <= shift_next;
        out_valid <= 1'b1;
      end else if (!word_done && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SERDES_RX_ERR_CNT_EN
  // Saturating error counter. A clear on the same edge wins over an increment.
  always_ff @(posedge serial_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if ((drop_evt || frame_evt) && (err_count != '1)) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: self-checking bench for serial_deserializer with
// WIDTH=32.
//
// A table of word records drives the main traffic. Each record gives the
// word, the out_ready setting and the expected holding-register state after
// completion.
//
// Hand-written sequences cover the framing error and the mid-word reset.
//
// A scoreboard queue receives each word that should reach the consumer. A
// monitor pops and compares one entry on every handshake.
module tb_serial_deserializer;

  localparam int WIDTH = 32;

  logic             serial_clk;
  logic             rst_n;
  logic             serial_data;
  logic             link_busy;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;
`ifdef SERDES_RX_ERR_CNT_EN
  logic [7:0]       err_count;
  logic             err_clr;
`endif

  serial_deserializer #(.WIDTH(WIDTH), .CNT_WIDTH(8)) dut (
    .serial_clk  (serial_clk),
    .rst_n       (rst_n),
    .serial_data (serial_data),
    .link_busy   (link_busy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef SERDES_RX_ERR_CNT_EN
    .err_count   (err_count),
    .err_clr     (err_clr),
`endif
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  initial serial_clk = 1'b0;
  always #5 serial_clk = ~serial_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ovr_cnt = 0;
  int fe_cnt  = 0;
  logic [31:0] exp_q[$];

  always @(posedge serial_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  always @(negedge serial_clk) begin
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", out_data, 32'hxxxx_xxxx);
        end else begin
          check("sb_word", out_data, exp_q.pop_front());
        end
      end
      if (overrun)   ovr_cnt++;
      if (frame_err) fe_cnt++;
      check("ovr_fe_exclusive", {31'd0, overrun && frame_err}, 32'd0);
    end
  end

  typedef struct {
    logic [31:0] word;
    logic        ready;       // out_ready while the word streams in
    logic        ready_last;  // out_ready on the completion edge
    int          gap;         // idle cycles after the word
    logic        push;        // word is expected to reach the consumer
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ovr;
  } row_t;

  row_t tbl[6];
  int   done_cyc[6];

  task automatic drive_bit(input logic b);
    @(negedge serial_clk);
    link_busy   = 1'b1;
    serial_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge serial_clk);
      link_busy   = 1'b0;
      serial_data = 1'b0;
    end
  endtask

  task automatic apply_row(input row_t r, input string tag, output int when);
    out_ready = r.ready;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge serial_clk);
      if (i == WIDTH - 1) begin
        out_ready = r.ready_last;
        if (r.push) exp_q.push_back(r.word);
      end
      link_busy   = 1'b1;
      serial_data = r.word[i];
    end
    @(posedge serial_clk);
    #1;
    when = cyc;
    check({tag, "_valid"},   {31'd0, out_valid}, {31'd0, r.exp_valid});
    check({tag, "_data"},    out_data, r.exp_data);
    check({tag, "_overrun"}, {31'd0, overrun},   {31'd0, r.exp_ovr});
    check({tag, "_frame"},   {31'd0, frame_err}, 32'd0);
    idle(r.gap);
  endtask

  initial begin
    int   dummy;
    logic [31:0] junk;

    //                word          rdy   rdy_l gap push  vld   exp_data      ovr
    tbl[0] = '{32'hA5A5_1234, 1'b1, 1'b1, 2, 1'b1, 1'b1, 32'hA5A5_1234, 1'b0};
    tbl[1] = '{32'h0000_0001, 1'b1, 1'b1, 0, 1'b1, 1'b1, 32'h0000_0001, 1'b0};
    tbl[2] = '{32'h8000_0000, 1'b1, 1'b1, 2, 1'b1, 1'b1, 32'h8000_0000, 1'b0};
    tbl[3] = '{32'h1111_1111, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h1111_1111, 1'b0};
    tbl[4] = '{32'h2222_2222, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h1111_1111, 1'b1};
    tbl[5] = '{32'h3333_3333, 1'b0, 1'b1, 2, 1'b1, 1'b1, 32'h3333_3333, 1'b0};

    rst_n       = 1'b0;
    link_busy   = 1'b0;
    serial_data = 1'b0;
    out_ready   = 1'b0;
`ifdef SERDES_RX_ERR_CNT_EN
    err_clr     = 1'b0;
`endif
    repeat (3) @(negedge serial_clk);
    check("rst_valid",   {31'd0, out_valid}, 32'd0);
    check("rst_data",    out_data, 32'd0);
    check("rst_overrun", {31'd0, overrun},   32'd0);
    check("rst_frame",   {31'd0, frame_err}, 32'd0);
`ifdef SERDES_RX_ERR_CNT_EN
    check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      apply_row(tbl[i], $sformatf("row%0d", i), done_cyc[i]);
`ifdef SERDES_RX_ERR_CNT_EN
      if (i == 4) check("backpressure_err_count", {24'd0, err_count}, 32'd1);
`endif
    end
    check("b2b_spacing", done_cyc[2] - done_cyc[1], 32'd32);

    // Framing error: the envelope drops after 10 bits of a word.
    out_ready = 1'b1;
    idle(2);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)));
    @(negedge serial_clk);
    link_busy = 1'b0;
    @(posedge serial_clk);
    #1;
    check("fe_pulse",     {31'd0, frame_err}, 32'd1);
    check("fe_valid",     {31'd0, out_valid}, 32'd0);
    check("fe_no_ovr",    {31'd0, overrun},   32'd0);
    @(posedge serial_clk);
    #1;
    check("fe_one_cycle", {31'd0, frame_err}, 32'd0);
    apply_row('{32'hDEAD_BEEF, 1'b1, 1'b1, 2, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0},
              "after_fe", dummy);

    // Reset in the middle of a word.
    for (int i = 0; i < 16; i++) drive_bit(1'($urandom_range(0, 1)));
    @(negedge serial_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
    check("mid_rst_data",    out_data, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun},   32'd0);
    check("mid_rst_frame",   {31'd0, frame_err}, 32'd0);
    exp_q.delete();
    link_busy = 1'b0;
    @(negedge serial_clk);
    rst_n = 1'b1;
    idle(2);
    apply_row('{32'h0F0F_0F0F, 1'b1, 1'b1, 3, 1'b1, 1'b1, 32'h0F0F_0F0F, 1'b0},
              "after_rst", dummy);

    check("overrun_pulses", ovr_cnt, 32'd1);
    check("frame_pulses",   fe_cnt,  32'd1);
    junk = 32'(exp_q.size());
    check("sb_drained",     junk,    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
